// File: rtl/wave_synth.sv
// Keypad note path output stage: phase accumulator, waveform select, ADSR-style
// envelope and PWM modulator producing an 8-bit sample plus a speaker bit stream.
module wave_synth #(
    parameter int ENV_STEP_CYCLES = 10000,
    parameter int PWM_W           = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [17:0] divider,
    input  logic [1:0]  mode,
    input  logic        strobe,
    output logic [7:0]  sample,
    output logic        pwm_out,
    output logic        active
);

    localparam int ENV_W = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
    localparam logic [ENV_W-1:0] ENV_LAST = ENV_W'(ENV_STEP_CYCLES - 1);

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

    env_state_t        state;
    logic [3:0]        env;
    logic [ENV_W-1:0]  env_cnt;
    logic              env_tick;

    logic [17:0]       lat_div;
    logic [1:0]        lat_mode;
    logic [17:0]       step_cnt;
    logic [7:0]        phase;
    logic [7:0]        lfsr;
    logic              lfsr_fb;
    logic              step_tick;
    logic              wrap;
    logic              load;

    logic [7:0]        raw;
    logic signed [8:0] d;
    logic signed [12:0] d_ext;
    logic signed [12:0] env_ext;
    logic signed [12:0] prod;
    logic [7:0]        sample_next;

    logic [PWM_W-1:0]  pwm_cnt;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    // >= rather than == keeps the counter bounded if the divider shrinks mid-count while idle.
    assign step_tick = (lat_div != '0) && (step_cnt >= lat_div - 18'd1);
    assign wrap      = step_tick && (phase == 8'hFF);
    assign load      = wrap || (state == IDLE) || (lat_div == '0);
    assign env_tick  = (env_cnt == ENV_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_cnt <= '0;
            phase    <= '0;
            lfsr     <= 8'h01;
            lat_div  <= '0;
            lat_mode <= '0;
        end else begin
            if (lat_div == '0) begin
                step_cnt <= '0;
                phase    <= '0;
            end else if (step_tick) begin
                step_cnt <= '0;
                phase    <= phase + 8'd1;
                lfsr     <= {lfsr[6:0], lfsr_fb};
            end else begin
                step_cnt <= step_cnt + 18'd1;
            end
            if (load) begin
                lat_div  <= divider;
                lat_mode <= mode;
            end
        end
    end

    always_comb begin
        raw = 8'h80;
        if (lat_div != '0) begin
            case (lat_mode)
                MODE_SQUARE: raw = phase[7] ? 8'hFF : 8'h00;
                MODE_SAW:    raw = phase;
                MODE_TRI:    raw = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
                default:     raw = lfsr;
            endcase
        end
    end

    // Scale the signed excursion around the midpoint by env/16; low byte wraps back to offset binary.
    always_comb begin
        d           = $signed({1'b0, raw}) - 9'sd128;
        d_ext       = {{4{d[8]}}, d};
        env_ext     = {9'd0, env};
        prod        = d_ext * env_ext;
        sample_next = 8'(prod >>> 4) + 8'h80;
    end

    // Envelope FSM: any state change clears the step counter; a transition beats a tick.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            env     <= '0;
            env_cnt <= '0;
            active  <= 1'b0;
        end else begin
            env_cnt <= env_tick ? '0 : env_cnt + 1'b1;
            active  <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (strobe) begin
                        state   <= ATTACK;
                        env_cnt <= '0;
                        active  <= 1'b1;
                    end
                end
                ATTACK: begin
                    if (!strobe) begin
                        state   <= RELEASE;
                        env_cnt <= '0;
                    end else if (env == 4'hF) begin
                        state   <= SUSTAIN;
                        env_cnt <= '0;
                    end else if (env_tick) begin
                        env <= env + 4'd1;
                        if (env == 4'hE) begin
                            state   <= SUSTAIN;
                            env_cnt <= '0;
                        end
                    end
                end
                SUSTAIN: begin
                    env <= 4'hF;
                    if (!strobe) begin
                        state   <= RELEASE;
                        env_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (strobe) begin
                        state   <= ATTACK;
                        env_cnt <= '0;
                    end else if (env == 4'h0) begin
                        state   <= IDLE;
                        env_cnt <= '0;
                        active  <= 1'b0;
                    end else if (env_tick) begin
                        env <= env - 4'd1;
                        if (env == 4'h1) begin
                            state   <= IDLE;
                            env_cnt <= '0;
                            active  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    env     <= '0;
                    env_cnt <= '0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample  <= 8'h80;
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            sample  <= sample_next;
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < PWM_W'(sample));
        end
    end

endmodule

// File: tb/tb_wave_synth.sv
// Scoreboard bench for wave_synth: an integer-level model predicts every cycle's
// outputs into a queue that an independent monitor drains against the DUT.
module tb_wave_synth;

    localparam int ENV_STEPS = 4;
    localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic [17:0] divider;
    logic [1:0]  mode;
    logic        strobe;
    logic [7:0]  sample;
    logic        pwm_out;
    logic        active;

    wave_synth #(.ENV_STEP_CYCLES(ENV_STEPS), .PWM_W(8)) dut (
        .clk(clk),
        .nrst(nrst),
        .divider(divider),
        .mode(mode),
        .strobe(strobe),
        .sample(sample),
        .pwm_out(pwm_out),
        .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sample;
        logic       pwm;
        logic       active;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int m_phase, m_step, m_div, m_mode, m_lfsr, m_env, m_state, m_envcnt;
    int m_pwmcnt, m_sample, m_pwm, m_active;

    function automatic void model_reset();
        m_phase = 0; m_step = 0; m_div = 0; m_mode = 0; m_lfsr = 1;
        m_env = 0; m_state = S_IDLE; m_envcnt = 0;
        m_pwmcnt = 0; m_sample = 128; m_pwm = 0; m_active = 0;
    endfunction

    function automatic int floor_div16(int p);
        return (p >= 0) ? p / 16 : -((-p + 15) / 16);
    endfunction

    function automatic void model_step(int div_in, int mode_in, int strobe_in);
        int raw, nxt_state, nxt_env, fb;
        bit wrap, tick, load;
        if (m_div == 0) raw = 128;
        else begin
            case (m_mode)
                0: raw = (m_phase >= 128) ? 255 : 0;
                1: raw = m_phase;
                2: raw = (m_phase < 128) ? 2 * m_phase : 255 - 2 * (m_phase - 128);
                default: raw = m_lfsr;
            endcase
        end
        m_pwm    = (m_pwmcnt < m_sample) ? 1 : 0;
        m_sample = 128 + floor_div16((raw - 128) * m_env);
        m_pwmcnt = (m_pwmcnt + 1) % 256;

        wrap = 0;
        load = (m_state == S_IDLE) || (m_div == 0);
        if (m_div == 0) begin
            m_step = 0;
            m_phase = 0;
        end else if (m_step >= m_div - 1) begin
            m_step = 0;
            wrap = (m_phase == 255);
            m_phase = (m_phase + 1) % 256;
            fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) & 255) | fb;
        end else begin
            m_step++;
        end
        if (wrap || load) begin
            m_div = div_in;
            m_mode = mode_in;
        end

        tick = (m_envcnt == ENV_STEPS - 1);
        nxt_state = m_state;
        nxt_env = m_env;
        case (m_state)
            S_IDLE: if (strobe_in != 0) nxt_state = S_ATTACK;
            S_ATTACK: begin
                if (strobe_in == 0) nxt_state = S_RELEASE;
                else if (m_env == 15) nxt_state = S_SUSTAIN;
                else if (tick) begin
                    nxt_env = m_env + 1;
                    if (nxt_env == 15) nxt_state = S_SUSTAIN;
                end
            end
            S_SUSTAIN: begin
                nxt_env = 15;
                if (strobe_in == 0) nxt_state = S_RELEASE;
            end
            default: begin
                if (strobe_in != 0) nxt_state = S_ATTACK;
                else if (m_env == 0) nxt_state = S_IDLE;
                else if (tick) begin
                    nxt_env = m_env - 1;
                    if (nxt_env == 0) nxt_state = S_IDLE;
                end
            end
        endcase
        m_envcnt = (nxt_state != m_state || tick) ? 0 : m_envcnt + 1;
        m_state  = nxt_state;
        m_env    = nxt_env;
        m_active = (nxt_state != S_IDLE) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int div_in, input int mode_in, input int strobe_in,
                                 input int rst_in, input int ncycles);
        exp_t e;
        repeat (ncycles) begin
            @(negedge clk);
            divider = 18'(div_in);
            mode    = 2'(mode_in);
            strobe  = (strobe_in != 0);
            nrst    = (rst_in == 0);
            if (rst_in != 0) model_reset();
            else model_step(div_in, mode_in, strobe_in);
            e.sample = 8'(m_sample);
            e.pwm    = (m_pwm != 0);
            e.active = (m_active != 0);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sample", sample, e.sample);
                checkOutput("pwm_out", {7'd0, pwm_out}, {7'd0, e.pwm});
                checkOutput("active", {7'd0, active}, {7'd0, e.active});
            end
        end
    end

    initial begin
        int d, md, sb, len;
        nrst = 1'b0;
        divider = '0;
        mode = '0;
        strobe = 1'b0;
        model_reset();

        applyStimulus(5, 0, 1, 1, 3);
        @(posedge clk); #2;
        checkOutput("reset_sample", sample, 8'h80);
        checkOutput("reset_pwm", {7'd0, pwm_out}, 8'd0);
        checkOutput("reset_active", {7'd0, active}, 8'd0);

        applyStimulus(5, 0, 1, 0, 2);
        @(posedge clk); #2;
        checkOutput("release_active", {7'd0, active}, 8'd1);

        applyStimulus(1, 0, 0, 1, 2);
        applyStimulus(1, 0, 1, 0, 400);
        @(posedge clk); #2;
        checkOutput("square_full_level", (sample == 8'hF7 || sample == 8'h08) ? 8'd1 : 8'd0, 8'd1);

        applyStimulus(1, 0, 0, 0, 80);
        @(posedge clk); #2;
        checkOutput("idle_sample", sample, 8'h80);
        checkOutput("idle_active", {7'd0, active}, 8'd0);

        applyStimulus(2, 1, 1, 0, 300);
        applyStimulus(3, 2, 1, 0, 900);
        applyStimulus(3, 2, 0, 0, 80);

        applyStimulus(0, 0, 1, 0, 80);
        @(posedge clk); #2;
        checkOutput("div0_sample", sample, 8'h80);
        checkOutput("div0_active", {7'd0, active}, 8'd1);
        applyStimulus(4, 1, 1, 0, 200);

        applyStimulus(4, 1, 0, 0, 24);
        applyStimulus(4, 1, 1, 0, 60);

        applyStimulus(1, 3, 0, 0, 80);
        applyStimulus(1, 3, 1, 0, 600);

        for (int seg = 0; seg < 60; seg++) begin
            d   = $urandom_range(0, 5);
            md  = $urandom_range(0, 3);
            sb  = $urandom_range(0, 1);
            len = $urandom_range(20, 120);
            if ($urandom_range(0, 19) == 0) applyStimulus(d, md, sb, 1, 2);
            applyStimulus(d, md, sb, 0, len);
        end

        @(posedge clk); #3;
        checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
